// File: rtl/mult_share_pkg.sv
// ============================================================================
// mult_share_pkg : shared types and helpers for the shared-multiplier scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package mult_share_pkg;

  localparam int OPW = 3;
  localparam int PW  = 6;

  typedef logic [OPW-1:0] op_t;
  typedef logic [PW-1:0]  prod_t;

  // LSB position of requester idx inside a flattened operand bus.
  function automatic int op_lsb(input int idx);
    return idx * OPW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_share_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin arbiter, searches upward from ptr with wrap-around
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_vld
);

  // Outer loop walks priority order (ptr, ptr+1, ...); inner loop keeps indices constant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en && !gnt_vld && req[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
          gnt[i]  = 1'b1;
          gnt_idx = IDW'(i);
          gnt_vld = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_share_sched.sv
// ============================================================================
// mult_share_sched : round-robin scheduler sharing one 3x3 multiplier, 2-stage pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OPW*NUM_REQ-1:0] req_a,
  input  logic [OPW*NUM_REQ-1:0] req_b,
  output logic [OPW-1:0]         mul_a,
  output logic [OPW-1:0]         mul_b,
  input  logic [PW-1:0]          mul_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [PW-1:0]          rsp_p
);

  logic           s1_valid_q, s1_valid_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  op_t            mul_a_q, mul_a_d;
  op_t            mul_b_q, mul_b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  prod_t          rsp_p_q, rsp_p_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic               s2_free, s1_free;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_vld;
  op_t                a_sel, b_sel;

  assign s2_free = !rsp_valid_q || rsp_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // rst_n gates the enable so req_ready is also forced low while reset is held.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (s1_free && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[op_lsb(i) +: OPW];
        b_sel = req_b[op_lsb(i) +: OPW];
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_id_d     = s1_id_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    rr_ptr_d    = rr_ptr_q;

    if (s1_valid_q && s2_free) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = s1_id_q;
      rsp_p_d     = mul_p;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    // Operand regs keep their last values when S1 empties without a new grant.
    if (gnt_vld) begin
      s1_valid_d = 1'b1;
      s1_id_d    = gnt_idx;
      mul_a_d    = a_sel;
      mul_b_d    = b_sel;
      rr_ptr_d   = IDW'((int'(gnt_idx) + 1) % NUM_REQ);
    end else if (s1_free) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req_ready = gnt;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_sched.sv
// ============================================================================
// tb_mult_share_sched : directed self-checking bench for mult_share_sched
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_share_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [3*N-1:0] req_a, req_b;
  logic [2:0]    mul_a, mul_b;
  logic [5:0]    mul_p;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [5:0]    rsp_p;

  int total = 0;
  int bad   = 0;

  logic [5:0] ops_of [N][64];
  int         cnt [N];
  int         head [N];
  int         waitc [N];
  logic [7:0] sb [$];
  logic [5:0] bp_exp [4];

  always #5 clk = ~clk;

  // Reference multiplier sitting beside the block.
  assign mul_p = {3'b000, mul_a} * {3'b000, mul_b};

  mult_share_sched #(.NUM_REQ(N), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    total++;
    if ({mul_a, mul_b} !== 6'd0) begin bad++; $display("FAIL reset_mul_ops: got %0d/%0d want 0/0", mul_a, mul_b); end
    total++;
    if ({rsp_valid, rsp_id, rsp_p} !== 9'd0) begin bad++; $display("FAIL reset_rsp: got v=%b id=%0d p=%0d want 0", rsp_valid, rsp_id, rsp_p); end
    rst_n = 1'b1;
    step;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_rsp: got %b want 0", rsp_valid); end
  endtask

  task automatic test_single;
    do_reset;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    req_a[5:3] = 3'd3;
    req_b[5:3] = 3'd5;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", req_ready); end
    step;
    req_valid = '0;
    total++;
    if (mul_a !== 3'd3 || mul_b !== 3'd5) begin bad++; $display("FAIL single_operands: got %0d,%0d want 3,5", mul_a, mul_b); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
    step;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 6'd15) begin
      bad++; $display("FAIL single_rsp: got v=%b id=%0d p=%0d want v=1 id=1 p=15", rsp_valid, rsp_id, rsp_p);
    end
    step;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_clear: got %b want 0", rsp_valid); end
  endtask

  task automatic test_all_four;
    logic [5:0] exp_p [4];
    exp_p[0] = 6'd49; exp_p[1] = 6'd6; exp_p[2] = 6'd0; exp_p[3] = 6'd24;
    do_reset;
    rsp_ready = 1'b1;
    req_a = {3'd6, 3'd0, 3'd2, 3'd7};
    req_b = {3'd4, 3'd5, 3'd3, 3'd7};
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      if (c >= 1 && c <= 4) req_valid[c-1] = 1'b0;
      #1;
      if (c >= 2) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(c-2) || rsp_p !== exp_p[c-2]) begin
          bad++; $display("FAIL all4_rsp%0d: got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d", c-2, rsp_valid, rsp_id, rsp_p, c-2, exp_p[c-2]);
        end
      end else begin
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL all4_early_rsp%0d: got %b want 0", c, rsp_valid); end
      end
      total++;
      if (c < 4) begin
        if (req_ready !== 4'(1 << c)) begin bad++; $display("FAIL all4_grant%0d: got %b want %b", c, req_ready, 4'(1 << c)); end
      end else begin
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL all4_idle%0d: got %b want 0000", c, req_ready); end
      end
      step;
    end
  endtask

  task automatic test_rr_wrap;
    do_reset;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_first: got %b want 0100", req_ready); end
    step;
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_to3: got %b want 1000", req_ready); end
    step;
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL wrap_to0: got %b want 0001", req_ready); end
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin bad++; $display("FAIL wrap_rsp_id: got v=%b id=%0d want v=1 id=2", rsp_valid, rsp_id); end
    step;
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    logic [N-1:0] g;
    int n;
    bp_exp[0] = 6'd2; bp_exp[1] = 6'd9; bp_exp[2] = 6'd20; bp_exp[3] = 6'd42;
    do_reset;
    rsp_ready = 1'b0;
    req_a = {3'd7, 3'd4, 3'd3, 3'd1};
    req_b = {3'd6, 3'd5, 3'd3, 3'd2};
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (c < 2) begin
        if (req_ready !== 4'(1 << c)) begin bad++; $display("FAIL bp_fill%0d: got %b want %b", c, req_ready, 4'(1 << c)); end
      end else begin
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready%0d: got %b want 0000", c, req_ready); end
      end
      if (c >= 2) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 6'd2) begin
          bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d p=%0d want v=1 id=0 p=2", c, rsp_valid, rsp_id, rsp_p);
        end
      end
      g = req_ready;
      step;
      req_valid = req_valid & ~g;
    end
    rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid && rsp_ready) begin
        total++;
        if (n >= 4) begin
          bad++; $display("FAIL bp_extra_rsp: got id=%0d p=%0d want none", rsp_id, rsp_p);
        end else if (rsp_id !== 2'(n) || rsp_p !== bp_exp[n]) begin
          bad++; $display("FAIL bp_order%0d: got id=%0d p=%0d want id=%0d p=%0d", n, rsp_id, rsp_p, n, bp_exp[n]);
        end
        n++;
      end
      g = req_ready;
      step;
      req_valid = req_valid & ~g;
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", n); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    rsp_ready = 1'b0;
    req_a = {6'd0, 3'd6, 3'd5};
    req_b = {6'd0, 3'd6, 3'd5};
    req_valid = 4'b0011;
    step;
    req_valid = 4'b0010;
    step;
    req_valid = 4'b0100;
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_p !== 6'd25) begin bad++; $display("FAIL mid_full: got v=%b p=%0d want v=1 p=25", rsp_valid, rsp_p); end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p} !== 19'd0) begin
      bad++; $display("FAIL mid_async_clear: got rdy=%b a=%0d b=%0d v=%b id=%0d p=%0d want all 0", req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p);
    end
    step;
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_rsp%0d: got %b want 0", c, rsp_valid); end
      step;
    end
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr_restart: got %b want 0001", req_ready); end
    step;
    req_valid = '0;
    repeat (3) step;
  endtask

  task automatic test_exhaustive;
    logic [N-1:0] g;
    logic [7:0]   e;
    logic [2:0]   a, b;
    int got, cyc, r;
    do_reset;
    sb.delete();
    for (int i = 0; i < N; i++) begin cnt[i] = 0; head[i] = 0; waitc[i] = 0; end
    for (int k = 0; k < 64; k++) begin
      r = int'($urandom_range(0, N-1));
      ops_of[r][cnt[r]] = 6'(k);
      cnt[r]++;
    end
    got = 0;
    cyc = 0;
    while (got < 64 && cyc < 3000) begin
      for (int i = 0; i < N; i++) begin
        if (head[i] < cnt[i]) begin
          req_valid[i] = 1'b1;
          req_a[i*3 +: 3] = ops_of[i][head[i]][5:3];
          req_b[i*3 +: 3] = ops_of[i][head[i]][2:0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rsp_valid && rsp_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL ex_unexpected_rsp: got id=%0d p=%0d want none", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_p} !== e) begin
            bad++; $display("FAIL ex_rsp: got id=%0d p=%0d want id=%0d p=%0d", rsp_id, rsp_p, e[7:6], e[5:0]);
          end
        end
        got++;
      end
      total++;
      if ((req_ready & ~req_valid) != '0 || $countones(req_ready) > 1) begin
        bad++; $display("FAIL ex_ready_onehot: got %b with valid %b want one-hot subset", req_ready, req_valid);
      end
      g = req_ready;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          a = req_a[i*3 +: 3];
          b = req_b[i*3 +: 3];
          sb.push_back({2'(i), {3'b000, a} * {3'b000, b}});
          waitc[i] = 0;
        end else if (!req_valid[i]) begin
          waitc[i] = 0;
        end else if (g != '0) begin
          waitc[i]++;
          total++;
          if (waitc[i] >= N) begin bad++; $display("FAIL ex_fairness: req %0d waited %0d grants want < %0d", i, waitc[i], N); end
        end
      end
      step;
      for (int i = 0; i < N; i++) if (g[i]) head[i]++;
      cyc++;
    end
    total++;
    if (got != 64 || sb.size() != 0) begin
      bad++; $display("FAIL ex_complete: got %0d responses (%0d pending) want 64 (0 pending)", got, sb.size());
    end
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    test_reset;
    test_single;
    test_all_four;
    test_rr_wrap;
    test_backpressure;
    test_reset_mid;
    test_exhaustive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
